// File: rtl/kdf_lane_sched.sv
// Round-robin KDF lane scheduler: dispatches jobs to LANES engines
// and retires results strictly in acceptance order.
module kdf_lane_sched #(
    parameter int PASSWD_LEN = 80,
    parameter int SALT_LEN   = 80,
    parameter int OUTPUT_LEN = 32,
    parameter int LANES      = 4,
    parameter int LW         = $clog2(LANES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_vld,
    output logic                           in_rdy,
    input  logic [PASSWD_LEN*8-1:0]        password,
    input  logic [SALT_LEN*8-1:0]          salt,
    input  logic                           salt_mode,
    output logic [LANES-1:0]               eng_in_vld,
    input  logic [LANES-1:0]               eng_in_rdy,
    output logic [LANES*PASSWD_LEN*8-1:0]  eng_password,
    output logic [LANES*SALT_LEN*8-1:0]    eng_salt,
    input  logic [LANES-1:0]               eng_out_vld,
    output logic [LANES-1:0]               eng_out_rdy,
    input  logic [LANES*OUTPUT_LEN*8-1:0]  eng_data,
    output logic                           out_vld,
    input  logic                           out_rdy,
    output logic [OUTPUT_LEN*8-1:0]        data_out,
    output logic [PASSWD_LEN*8-1:0]        password_o,
    output logic [LW-1:0]                  out_lane,
    output logic [$clog2(LANES+1)-1:0]     lanes_busy
);

    localparam int PW = PASSWD_LEN * 8;
    localparam int SW = SALT_LEN * 8;
    localparam int OW = OUTPUT_LEN * 8;
    localparam int BW = $clog2(LANES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RUN,
        DONE
    } lane_st_t;

    lane_st_t        st     [LANES];
    logic [PW-1:0]   pw_r   [LANES];
    logic [SW-1:0]   salt_r [LANES];
    logic [OW-1:0]   res_r  [LANES];

    logic [LW-1:0]   dp;
    logic [LW-1:0]   rp;
    logic [BW-1:0]   busy;

    logic [SW-1:0]   pw_salt;
    logic [SW-1:0]   eff_salt;
    logic            in_hs;
    logic            out_hs;

    generate
        if (SALT_LEN <= PASSWD_LEN) begin : g_salt_trunc
            assign pw_salt = password[SW-1:0];
        end else begin : g_salt_ext
            assign pw_salt = {{(SW-PW){1'b0}}, password};
        end
    endgenerate

    assign eff_salt   = salt_mode ? pw_salt : salt;
    assign in_rdy     = (st[dp] == IDLE);
    assign out_vld    = (st[rp] == DONE);
    assign in_hs      = in_vld && in_rdy;
    assign out_hs     = out_vld && out_rdy;
    assign data_out   = res_r[rp];
    assign password_o = pw_r[rp];
    assign out_lane   = rp;
    assign lanes_busy = busy;

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            assign eng_in_vld[g]          = (st[g] == ISSUE);
            assign eng_out_rdy[g]         = (st[g] == RUN);
            assign eng_password[g*PW+:PW] = pw_r[g];
            assign eng_salt[g*SW+:SW]     = salt_r[g];
        end
    endgenerate

    // Only IDLE->ISSUE and DONE->IDLE change occupancy, so the
    // busy count tracks the two handshakes directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp   <= '0;
            rp   <= '0;
            busy <= '0;
            for (int i = 0; i < LANES; i++) begin
                st[i]     <= IDLE;
                pw_r[i]   <= '0;
                salt_r[i] <= '0;
                res_r[i]  <= '0;
            end
        end else begin
            if (in_hs) dp <= dp + 1'b1;
            if (out_hs) rp <= rp + 1'b1;
            busy <= busy + BW'(in_hs) - BW'(out_hs);
            for (int i = 0; i < LANES; i++) begin
                unique case (st[i])
                    IDLE: begin
                        if (in_hs && dp == LW'(i)) begin
                            st[i]     <= ISSUE;
                            pw_r[i]   <= password;
                            salt_r[i] <= eff_salt;
                        end
                    end
                    ISSUE: begin
                        if (eng_in_rdy[i]) st[i] <= RUN;
                    end
                    RUN: begin
                        if (eng_out_vld[i]) begin
                            st[i]    <= DONE;
                            res_r[i] <= eng_data[i*OW+:OW];
                        end
                    end
                    DONE: begin
                        if (out_hs && rp == LW'(i)) st[i] <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kdf_lane_sched.sv
// Scoreboard bench for kdf_lane_sched with a behavioural
// per-lane engine model and a SALT_LEN=96 side instance.
module tb_kdf_lane_sched;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_vld;
    logic          in_rdy;
    logic [639:0]  password;
    logic [639:0]  salt;
    logic          salt_mode;
    logic [3:0]    eng_in_vld;
    logic [3:0]    eng_in_rdy;
    logic [2559:0] eng_password;
    logic [2559:0] eng_salt;
    logic [3:0]    eng_out_vld;
    logic [3:0]    eng_out_rdy;
    logic [1023:0] eng_data;
    logic          out_vld;
    logic          out_rdy;
    logic [255:0]  data_out;
    logic [639:0]  password_o;
    logic [1:0]    out_lane;
    logic [2:0]    lanes_busy;

    logic          in_vld2;
    logic          in_rdy2;
    logic [767:0]  salt2;
    logic [1:0]    eng_in_vld2;
    logic [1279:0] eng_password2;
    logic [1535:0] eng_salt2;
    logic [1:0]    eng_out_rdy2;
    logic          out_vld2;
    logic [255:0]  data_out2;
    logic [639:0]  password_o2;
    logic [0:0]    out_lane2;
    logic [1:0]    lanes_busy2;

    always #5 clk = ~clk;

    kdf_lane_sched u_dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy),
        .password(password), .salt(salt), .salt_mode(salt_mode),
        .eng_in_vld(eng_in_vld), .eng_in_rdy(eng_in_rdy),
        .eng_password(eng_password), .eng_salt(eng_salt),
        .eng_out_vld(eng_out_vld), .eng_out_rdy(eng_out_rdy),
        .eng_data(eng_data),
        .out_vld(out_vld), .out_rdy(out_rdy),
        .data_out(data_out), .password_o(password_o),
        .out_lane(out_lane), .lanes_busy(lanes_busy)
    );

    kdf_lane_sched #(.SALT_LEN(96), .LANES(2)) u_dut96 (
        .clk(clk), .rst(rst),
        .in_vld(in_vld2), .in_rdy(in_rdy2),
        .password(password), .salt(salt2), .salt_mode(1'b1),
        .eng_in_vld(eng_in_vld2), .eng_in_rdy(2'b00),
        .eng_password(eng_password2), .eng_salt(eng_salt2),
        .eng_out_vld(2'b00), .eng_out_rdy(eng_out_rdy2),
        .eng_data('0),
        .out_vld(out_vld2), .out_rdy(1'b1),
        .data_out(data_out2), .password_o(password_o2),
        .out_lane(out_lane2), .lanes_busy(lanes_busy2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [767:0] act,
                         input logic [767:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] kdf_f(input logic [639:0] p);
        return p[255:0] ^ {32{8'h54}};
    endfunction

    function automatic logic [639:0] rnd640();
        logic [639:0] r;
        for (int i = 0; i < 20; i++) r[i*32+:32] = $urandom;
        return r;
    endfunction

    // Engine model: fixed per-lane reply delay, holds result until taken.
    logic [3:0]   ebusy;
    int           ecnt  [4];
    logic [255:0] edata [4];
    int           delay [4];
    logic [3:0]   rdy_en;

    assign eng_in_rdy = rdy_en & ~ebusy;
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            eng_out_vld[i]         = ebusy[i] && (ecnt[i] == 0);
            eng_data[i*256+:256]   = edata[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                ebusy[i] <= 1'b0;
                ecnt[i]  <= 0;
                edata[i] <= '0;
            end else if (!ebusy[i]) begin
                if (eng_in_vld[i] && eng_in_rdy[i]) begin
                    ebusy[i] <= 1'b1;
                    ecnt[i]  <= delay[i];
                    edata[i] <= kdf_f(eng_password[i*640+:640]);
                end
            end else if (ecnt[i] != 0) begin
                ecnt[i] <= ecnt[i] - 1;
            end else if (eng_out_rdy[i]) begin
                ebusy[i] <= 1'b0;
            end
        end
    end

    typedef struct {
        logic [255:0] data;
        logic [639:0] pw;
        logic [1:0]   lane;
    } exp_t;

    exp_t         sb [$];
    logic [639:0] lane_pw   [4];
    logic [639:0] lane_salt [4];
    logic [1:0]   mdp = '0;
    int           retired = 0;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            mdp = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (eng_in_vld[i] && eng_in_rdy[i]) begin
                    check("eng_pw", eng_password[i*640+:640], lane_pw[i]);
                    check("eng_salt", eng_salt[i*640+:640], lane_salt[i]);
                end
            end
            if (out_vld && out_rdy) begin
                retired++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("data_out", data_out, e.data);
                    check("password_o", password_o, e.pw);
                    check("out_lane", out_lane, e.lane);
                end
            end
            if (in_vld && in_rdy) begin
                sb.push_back('{kdf_f(password), password, mdp});
                lane_pw[mdp]   = password;
                lane_salt[mdp] = salt_mode ? password : salt;
                mdp = mdp + 1'b1;
            end
        end
    end

    task automatic send(input logic [639:0] pw, input logic [639:0] s,
                        input logic sm);
        int n = 0;
        password  = pw;
        salt      = s;
        salt_mode = sm;
        in_vld    = 1'b1;
        @(negedge clk);
        while (!in_rdy && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!in_rdy) begin
            check("send_timeout", 0, 1);
            in_vld = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst    = 1'b1;
        in_vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((lanes_busy != 0 || sb.size() != 0) && n < 500) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("drain_timeout", (n < 500), 1);
    endtask

    task automatic wait_cyc(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    logic [639:0] pw_snap;
    logic [255:0] d_snap;
    logic [1:0]   l_snap;
    logic         stable;
    int           k;

    initial begin
        #300000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_vld2 = 1'b0; out_rdy = 1'b1;
        password = '0; salt = '0; salt_mode = 1'b0; salt2 = '0;
        rdy_en = 4'hF;
        for (int i = 0; i < 4; i++) delay[i] = 10;
        wait_cyc(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_rdy", in_rdy, 1);
        check("rst_out_vld", out_vld, 0);
        check("rst_busy", lanes_busy, 0);
        check("rst_eng_in_vld", eng_in_vld, 0);
        check("rst_eng_out_rdy", eng_out_rdy, 0);
        check("rst_data_out", data_out, 0);
        check("rst_password_o", password_o, 0);
        check("rst_out_lane", out_lane, 0);
        @(posedge clk);
        #1;

        send({80{8'h01}}, {80{8'hAA}}, 1'b0);
        @(negedge clk);
        check("t1_eng_in_vld", eng_in_vld, 4'b0001);
        check("t1_busy", lanes_busy, 1);
        @(posedge clk);
        #1;
        drain();

        for (int i = 0; i < 4; i++) delay[i] = 0;
        send(rnd640(), rnd640(), 1'b0);
        k = 1;
        @(negedge clk);
        while (!out_vld && k < 10) begin
            k++;
            @(negedge clk);
        end
        check("min_latency", k, 3);
        @(posedge clk);
        #1;
        drain();

        do_reset();
        delay[0] = 20; delay[1] = 12; delay[2] = 30; delay[3] = 5;
        for (int i = 0; i < 4; i++) send(rnd640(), rnd640(), 1'b0);
        retired   = 0;
        password  = rnd640();
        salt      = rnd640();
        in_vld    = 1'b1;
        @(negedge clk);
        check("full_stall", in_rdy, 0);
        check("full_busy", lanes_busy, 4);
        k = 0;
        while (!in_rdy && k < 300) begin
            k++;
            @(negedge clk);
        end
        check("stall_until_retire", (retired >= 1), 1);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        drain();

        do_reset();
        for (int i = 0; i < 4; i++) delay[i] = 4;
        send(rnd640(), rnd640(), 1'b1);
        send(rnd640(), rnd640(), 1'b1);
        drain();
        password = rnd640();
        in_vld2  = 1'b1;
        @(negedge clk);
        check("s96_in_rdy", in_rdy2, 1);
        @(posedge clk);
        #1;
        in_vld2 = 1'b0;
        @(negedge clk);
        check("s96_vld", eng_in_vld2, 2'b01);
        check("s96_salt", eng_salt2[767:0], {128'b0, password});

        do_reset();
        for (int i = 0; i < 4; i++) delay[i] = 3;
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send(rnd640(), rnd640(), 1'b0);
        wait_cyc(10);
        @(negedge clk);
        pw_snap = password_o; d_snap = data_out; l_snap = out_lane;
        stable  = 1'b1;
        check("bp_busy", lanes_busy, 4);
        check("bp_lane", out_lane, 0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!out_vld || password_o !== pw_snap || data_out !== d_snap ||
                out_lane !== l_snap) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        k = 0;
        @(negedge clk);
        while (out_vld && k < 10) begin
            k++;
            @(negedge clk);
        end
        check("bp_burst", k, 4);
        drain();

        do_reset();
        for (int i = 0; i < 4; i++) delay[i] = 10;
        rdy_en[1] = 1'b0;
        for (int i = 0; i < 4; i++) send(rnd640(), rnd640(), 1'b0);
        @(negedge clk);
        pw_snap = eng_password[1*640+:640];
        wait_cyc(2);
        @(negedge clk);
        check("l1_held", eng_in_vld[1], 1);
        check("l1_pw_stable", eng_password[1*640+:640], pw_snap);
        check("l23_dispatched", {eng_in_vld[3], eng_in_vld[2]}, 2'b00);
        @(posedge clk);
        #1;
        rdy_en[1] = 1'b1;
        drain();

        do_reset();
        for (int i = 0; i < 4; i++) delay[i] = 40;
        for (int i = 0; i < 3; i++) send(rnd640(), rnd640(), 1'b0);
        check("pre_rst_busy", lanes_busy, 3);
        do_reset();
        @(negedge clk);
        check("mid_rst_busy", lanes_busy, 0);
        check("mid_rst_out_vld", out_vld, 0);
        check("mid_rst_in_rdy", in_rdy, 1);
        check("mid_rst_out_lane", out_lane, 0);
        check("mid_rst_eng_vld", eng_in_vld, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) delay[i] = 2;
        send(rnd640(), rnd640(), 1'b0);
        @(negedge clk);
        check("post_rst_lane0", eng_in_vld, 4'b0001);
        @(posedge clk);
        #1;
        drain();

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/kdf_lane_sched.md
# kdf_lane_sched

Multi-lane job scheduler for the fast-KDF stage. Accepts password/salt jobs from the test-bench side, dispatches them round-robin to `LANES` independent KDF engine instances, collects their results, and re-emits them strictly in acceptance order toward the DBL_MIX consumers. Adds a salt-from-password mode and per-lane result buffering, so several KDF jobs overlap instead of running one at a time.

## Interface
- `PASSWD_LEN`, 80, password bytes
- `SALT_LEN`, 80, salt bytes
- `OUTPUT_LEN`, 32, KDF result bytes
- `LANES`, 4, engine lanes; power of two, 2..16
- `LW`, $clog2(LANES), lane index width (derived)

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_vld`  in  1  job valid
- `in_rdy`  out  1  job accepted when `in_vld && in_rdy`
- `password`  in  PASSWD_LEN*8  job password
- `salt`  in  SALT_LEN*8  job salt
- `salt_mode`  in  1  0: use `salt`; 1: effective salt = `password` low SALT_LEN bytes, zero-extended if SALT_LEN > PASSWD_LEN
- `eng_in_vld`  out  LANES  per-lane job valid
- `eng_in_rdy`  in  LANES  per-lane engine ready
- `eng_password`  out  LANES*PASSWD_LEN*8  per-lane password; lane i at slice i
- `eng_salt`  out  LANES*SALT_LEN*8  per-lane effective salt
- `eng_out_vld`  in  LANES  per-lane result valid
- `eng_out_rdy`  out  LANES  per-lane result ready
- `eng_data`  in  LANES*OUTPUT_LEN*8  per-lane result
- `out_vld`  out  1  ordered result valid
- `out_rdy`  in  1  downstream ready
- `data_out`  out  OUTPUT_LEN*8  result
- `password_o`  out  PASSWD_LEN*8  password of the job that produced `data_out`
- `out_lane`  out  LW  lane that produced the result
- `lanes_busy`  out  $clog2(LANES+1)  count of lanes not IDLE

## Operation
- Per-lane FSM: IDLE -> ISSUE -> RUN -> DONE -> IDLE.
  - IDLE -> ISSUE: on input handshake while the dispatch pointer `dp` equals the lane. Password and effective salt are captured into lane registers.
  - ISSUE: `eng_in_vld[i]=1`, with the lane registers driven on the lane's slices. Moves to RUN on `eng_in_rdy[i]`.
  - RUN: `eng_out_rdy[i]=1`. On `eng_out_vld[i]`, `eng_data` slice is captured into the lane result register, and the lane moves to DONE.
  - DONE -> IDLE: on output handshake while the retire pointer `rp` equals the lane.
- `in_rdy = (state[dp]==IDLE)`. This depends only on registered state, never on `out_rdy`.
- `dp` increments modulo LANES on each input handshake.
- `rp` increments modulo LANES on each output handshake.
- Ordering rule: job k runs on lane k mod LANES and retires in k order, so no tags are needed.
- Output is driven from lane `rp`:
  - `out_vld = (state[rp]==DONE)`
  - `data_out`, `password_o` come from the lane `rp` registers
  - `out_lane = rp`
- Out-of-order completion: a lane in DONE with lane ≠ `rp` holds its result, stalls its own re-dispatch, and keeps `eng_out_rdy` low.
- Full: all lanes non-IDLE, so `in_rdy=0`. Empty: all lanes IDLE, so `out_vld=0`.
- Simultaneous input and output handshakes on the same lane index: both take effect. The lane freed by output becomes IDLE next cycle; it is not reused in the same cycle.
- Backpressure: `out_rdy=0` holds `out_vld`, `data_out`, `password_o` and `out_lane` stable.
- `lanes_busy` is the registered count of lanes not IDLE. It is updated the same cycle as the state registers.

## Timing
- Reset (sync, `rst=1` at a clock edge) puts the block in this state:
  - all lanes IDLE, `dp=rp=0`
  - all data registers 0
  - outputs: `in_rdy=1`, `eng_in_vld=0`, `eng_out_rdy=0`, `out_vld=0`, `data_out=0`, `password_o=0`, `out_lane=0`, `lanes_busy=0`
- Reset mid-operation discards all in-flight jobs. Engines are reset on the same `rst`.
- Minimum latency, with input accepted at edge t:
  - `eng_in_vld` high in cycle t+1
  - if `eng_in_rdy` is high in t+1, `eng_out_rdy` is high from t+2
  - a result with `eng_out_vld` in t+2 gives `out_vld` in t+3
- Throughput: one job per cycle until all lanes are occupied.
- Valid/ready rules: every valid, once asserted, stays high with stable data until its handshake.

## Test plan
- Single job, LANES=4, `salt_mode=0`, password=0x01.., salt=0xAA.., engine returns 0x55.. after 10 cycles -> `eng_in_vld[0]` at t+1; `out_vld` with `data_out`=0x55.. and `out_lane=0`; `password_o` = input password.
- Four back-to-back jobs, engines reply in order 3,1,0,2 -> outputs in order lanes 0,1,2,3 with matching data; fifth job stalls (`in_rdy=0`) until lane 0 retires.
- `salt_mode=1`, SALT_LEN=80, PASSWD_LEN=80 -> `eng_salt` slice equals password. Repeat with SALT_LEN=96 -> upper 16 bytes are 0.
- Backpressure: `out_rdy` low 20 cycles with all lanes DONE -> `out_vld` held, data stable, `lanes_busy=4`; after release, four results in consecutive cycles.
- `eng_in_rdy` low 5 cycles on lane 1 -> `eng_in_vld[1]` and its slices stable; lanes 2 and 3 still dispatch.
- Assert `rst` with 3 lanes busy -> next cycle `lanes_busy=0`, `out_vld=0`, `in_rdy=1`, `dp=rp=0`; the next job goes to lane 0.
